// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ requesters.
// Supports locked bursts, and drives the write port from a registered stage.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        hold,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_dest,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rf_write_e,
    output logic [ADDR_W-1:0]           rf_write_dest,
    output logic [DATA_W-1:0]           rf_write_data,
    output logic [ID_W-1:0]             grant_id,
    output logic                        lock_active
);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    state_t             fsm_q, fsm_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ID_W-1:0]    gid_q, gid_d;

    logic [ADDR_W-1:0]  dest_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      cand;
    logic               fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign dest_arr[gi] = req_dest[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Grant selection: the owner alone while locked, else first valid after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (fsm_q == LOCKED) begin
            if (req_valid[owner_q]) begin
                grant_found = 1'b1;
                grant_idx   = owner_q;
            end
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
                if (cand >= NUM_REQ_W) begin
                    cand = cand - NUM_REQ_W;
                end
                if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand[ID_W-1:0];
                end
            end
        end
    end

    assign fire = rst_n && !hold && grant_found;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        we_d     = fire;
        dest_d   = dest_q;
        data_d   = data_q;
        gid_d    = gid_q;
        if (fire) begin
            rr_ptr_d = grant_idx;
            dest_d   = dest_arr[grant_idx];
            data_d   = data_arr[grant_idx];
            gid_d    = grant_idx;
            if (fsm_q == ARB) begin
                if (req_lock[grant_idx]) begin
                    owner_d = grant_idx;
                    fsm_d   = LOCKED;
                end
            end else if (!req_lock[grant_idx]) begin
                fsm_d = ARB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= ARB;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            owner_q  <= '0;
            we_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
            gid_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
        end
    end

    assign rf_write_e    = we_q;
    assign rf_write_dest = dest_q;
    assign rf_write_data = data_q;
    assign grant_id      = gid_q;
    assign lock_active   = (fsm_q == LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter: reset, single grant, rotation,
// locked bursts, hold and reset while locked.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_lock = '0;
    logic [15:0] req_dest = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        rf_write_e;
    logic [3:0]  rf_write_dest;
    logic [15:0] rf_write_data;
    logic [1:0]  grant_id;
    logic        lock_active;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_write_arbiter #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready), .rf_write_e(rf_write_e),
        .rf_write_dest(rf_write_dest), .rf_write_data(rf_write_data),
        .grant_id(grant_id), .lock_active(lock_active)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_dest(int i);
        return 4'(i * 3 + 1);
    endfunction

    function automatic logic [15:0] exp_data(int i);
        return 16'hA000 + 16'(i);
    endfunction

    task automatic load_defaults();
        for (int i = 0; i < 4; i++) begin
            req_dest[i*4 +: 4]   = exp_dest(i);
            req_data[i*16 +: 16] = exp_data(i);
        end
    endtask

    // Leaves time at posedge+1 with reset released and rr_ptr at 3.
    task automatic do_reset();
        rst_n = 1'b0; hold = 1'b0; req_valid = '0; req_lock = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [23:0] outs;
        rst_n = 1'b0; req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_ready cyc=%0d got %b want 0000", k, req_ready);
            end
            outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
            tests_run++;
            if (outs !== 24'h0) begin
                tests_failed++;
                $display("FAIL reset_outs cyc=%0d got %h want 000000", k, outs);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [23:0] outs;
        req_dest[7:4] = 4'd5; req_data[31:16] = 16'hBEEF; req_valid = 4'b0010;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL single_ready got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
        tests_run++;
        if (outs !== {1'b1, 2'd1, 4'd5, 16'hBEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_write got %h want %h", outs, {1'b1, 2'd1, 4'd5, 16'hBEEF, 1'b0});
        end
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_idle_ready got %b want 0000", req_ready);
        end
        @(posedge clk); #1;
        outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
        tests_run++;
        if (outs !== {1'b0, 2'd1, 4'd5, 16'hBEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_hold_vals got %h want %h", outs, {1'b0, 2'd1, 4'd5, 16'hBEEF, 1'b0});
        end
        load_defaults();
    endtask

    task automatic test_round_robin();
        int          g_tab [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [23:0] outs, want;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if (req_ready !== (4'b0001 << g_tab[k])) begin
                tests_failed++;
                $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, 4'b0001 << g_tab[k]);
            end
            @(posedge clk); #1;
            outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
            want = {1'b1, 2'(g_tab[k]), exp_dest(g_tab[k]), exp_data(g_tab[k]), 1'b0};
            tests_run++;
            if (outs !== want) begin
                tests_failed++;
                $display("FAIL rr_write k=%0d got %h want %h", k, outs, want);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_lock();
        logic [3:0]  v_tab [7] = '{4'b1101, 4'b1101, 4'b1001, 4'b1101, 4'b1101, 4'b1001, 4'b1001};
        logic [3:0]  l_tab [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  r_tab [7] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        logic        w_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int          g_tab [7] = '{2, 2, 2, 2, 2, 3, 0};
        logic        a_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [23:0] outs, want;
        do_reset();
        req_valid = 4'b0010;
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            req_valid = v_tab[k]; req_lock = l_tab[k];
            #1;
            tests_run++;
            if (req_ready !== r_tab[k]) begin
                tests_failed++;
                $display("FAIL lock_ready k=%0d got %b want %b", k, req_ready, r_tab[k]);
            end
            @(posedge clk); #1;
            outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
            want = {w_tab[k], 2'(g_tab[k]), exp_dest(g_tab[k]), exp_data(g_tab[k]), a_tab[k]};
            tests_run++;
            if (outs !== want) begin
                tests_failed++;
                $display("FAIL lock_write k=%0d got %h want %h", k, outs, want);
            end
        end
        req_valid = '0; req_lock = '0;
    endtask

    task automatic test_hold();
        logic        h_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  r_tab [6] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        logic        w_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          g_tab [6] = '{0, 1, 1, 1, 0, 1};
        logic [23:0] outs, want;
        do_reset();
        req_valid = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            hold = h_tab[k];
            #1;
            tests_run++;
            if (req_ready !== r_tab[k]) begin
                tests_failed++;
                $display("FAIL hold_ready k=%0d got %b want %b", k, req_ready, r_tab[k]);
            end
            @(posedge clk); #1;
            outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
            want = {w_tab[k], 2'(g_tab[k]), exp_dest(g_tab[k]), exp_data(g_tab[k]), 1'b0};
            tests_run++;
            if (outs !== want) begin
                tests_failed++;
                $display("FAIL hold_write k=%0d got %h want %h", k, outs, want);
            end
        end
        hold = 1'b0; req_valid = '0;
    endtask

    task automatic test_reset_locked();
        logic [23:0] outs, want;
        do_reset();
        req_valid = 4'b0010; req_lock = 4'b0010;
        @(posedge clk); #1;
        outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
        want = {1'b1, 2'd1, exp_dest(1), exp_data(1), 1'b1};
        tests_run++;
        if (outs !== want) begin
            tests_failed++;
            $display("FAIL rstlk_enter got %h want %h", outs, want);
        end
        req_valid = 4'b1010; rst_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rstlk_ready_in_reset got %b want 0000", req_ready);
        end
        @(posedge clk); #1;
        outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
        tests_run++;
        if (outs !== 24'h0) begin
            tests_failed++;
            $display("FAIL rstlk_cleared got %h want 000000", outs);
        end
        rst_n = 1'b1; req_lock = 4'b0000;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rstlk_first_grant got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        outs = {rf_write_e, grant_id, rf_write_dest, rf_write_data, lock_active};
        want = {1'b1, 2'd1, exp_dest(1), exp_data(1), 1'b0};
        tests_run++;
        if (outs !== want) begin
            tests_failed++;
            $display("FAIL rstlk_after got %h want %h", outs, want);
        end
        req_valid = '0;
    endtask

    initial begin
        load_defaults();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_hold();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
